// File: rtl/jrb8_pkg.sv
// Shared types and defaults for the jrb8 program loader.
package jrb8_pkg;
  localparam int         ADDR_W_DEF    = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR
  } ld_state_e;
endpackage

// File: rtl/jrb8_prog_loader_if.sv
// Host strobe/ack pins plus the program RAM write port.
interface jrb8_prog_loader_if #(parameter int ADDR_W = 16);
  logic [7:0]        host_data;
  logic              host_stb;
  logic              host_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;

  modport slave  (input  host_data, host_stb, output host_ack, mem_addr, mem_wdata, mem_we);
  modport master (output host_data, host_stb, input  host_ack, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/jrb8_hs_sync.sv
// Synchronises host_stb and runs the 4-phase ack; pulses byte_valid once per stb high phase.
module jrb8_hs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_stb,
  input  logic [7:0] host_data,
  output logic       host_ack,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stb_prev_q, stb_prev_d;
  logic                   ack_q, ack_d;
  logic                   stb_s;

  assign stb_s      = sync_q[SYNC_STAGES-1];
  assign byte_valid = stb_s & ~stb_prev_q & ~ack_q;
  // host_data is held stable by the host until ack rises, so it is consumed directly.
  assign byte_data  = host_data;
  assign host_ack   = ack_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], host_stb};
    stb_prev_d = stb_s;
    ack_d      = ack_q;
    if (byte_valid)  ack_d = 1'b1;
    else if (!stb_s) ack_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q     <= '0;
      stb_prev_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      stb_prev_q <= stb_prev_d;
      ack_q      <= ack_d;
    end
  end
endmodule

// File: rtl/jrb8_prog_loader.sv
// Frame FSM: sync, length, payload writes to RAM from address 0, checksum verify.
module jrb8_prog_loader
  import jrb8_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  jrb8_prog_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);
  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d, idx_q, idx_d, addr_q, addr_d;
  logic [7:0]        acc_q, acc_d, wdata_q, wdata_d, sum;
  logic              we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic              bv;
  logic [7:0]        bd;

  jrb8_hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hs (
    .clk(clk), .rst_n(rst_n), .host_stb(bus.host_stb), .host_data(bus.host_data),
    .host_ack(bus.host_ack), .byte_valid(bv), .byte_data(bd)
  );

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sum           = acc_q + bd;

  always_comb begin
    state_d = state_q; len_d = len_q; idx_d = idx_q; acc_d = acc_q;
    addr_d  = addr_q;  wdata_d = wdata_q; we_d = 1'b0;
    hold_d  = hold_q;  done_d = done_q;  err_d = err_q;
    if (state_q != IDLE && !load_en) begin
      state_d = IDLE; hold_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load_en) begin
          state_d = SYNC; hold_d = 1'b1; done_d = 1'b0; err_d = 1'b0;
        end
        SYNC: if (bv) begin
          if (bd == SYNC_BYTE) state_d = LEN_LO;
          else begin state_d = ERROR; err_d = 1'b1; end
        end
        LEN_LO: if (bv) begin
          len_d = ADDR_W'(bd); state_d = LEN_HI;
        end
        LEN_HI: if (bv) begin
          len_d   = ADDR_W'({bd, len_q[7:0]});
          idx_d   = '0;
          acc_d   = '0;
          state_d = (len_d != '0) ? DATA : CSUM;
        end
        DATA: if (bv) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = bd;
          acc_d   = sum;
          idx_d   = idx_q + ADDR_W'(1);
          // Terminal compare on the pre-increment index keeps LEN=max from wrapping.
          if (idx_q == len_q - ADDR_W'(1)) state_d = CSUM;
        end
        CSUM: if (bv) begin
          if (sum == 8'd0) begin state_d = DONE; done_d = 1'b1; hold_d = 1'b0; end
          else begin state_d = ERROR; err_d = 1'b1; end
        end
        DONE, ERROR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      len_q   <= '0; idx_q <= '0; acc_q <= '0;
      addr_q  <= '0; wdata_q <= '0; we_q <= 1'b0;
      hold_q  <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d; idx_q <= idx_d; acc_q <= acc_d;
      addr_q  <= addr_d; wdata_q <= wdata_d; we_q <= we_d;
      hold_q  <= hold_d; done_q <= done_d; err_q <= err_d;
    end
  end
endmodule

// File: doc/jrb8_prog_loader.md
Name: jrb8_prog_loader

Overview:
Host-side program writer for the jrb8 8-bit computer. The CPU only reads program memory; this block is the writer that fills it. It receives a framed byte stream from an external host over a 4-phase strobe/ack handshake on the bidirectional IO pins and writes the payload sequentially into program RAM from address 0. While loading it holds the CPU and flags completion or error.

Parameters:
ADDR_W, 16, program memory address width; the length field is also ADDR_W bits.
SYNC_STAGES, 2, flip-flop stages on host_stb, minimum 2.
SYNC_BYTE, 8'hA5, required first byte of a frame.

Ports:
clk  input  1  system clock
rst_n  input  1  reset: asynchronous, active-high (asserted when 1)
load_en  input  1  level; 1 = loader armed or active, 0 = abort and idle
host_data  input  8  host byte; stable from before host_stb rises until host_ack rises
host_stb  input  1  host strobe; asynchronous to clk
host_ack  output  1  loader acknowledge
mem_addr  output  ADDR_W  program RAM write address
mem_wdata  output  8  program RAM write data
mem_we  output  1  one-cycle write strobe
cpu_hold  output  1  holds the CPU in reset while loading
done  output  1  frame loaded, checksum good
err  output  1  bad sync byte or bad checksum

Behaviour:
- Reset values: host_ack=0, mem_addr=0, mem_wdata=0, mem_we=0, cpu_hold=0, done=0, err=0, FSM=IDLE, counters=0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CSUM.
  - Checksum rule: the 8-bit sum of all payload bytes plus CSUM, modulo 256, equals 0.
- Handshake:
  - host_stb passes through SYNC_STAGES flops to give stb_s.
  - A rising edge of stb_s with host_ack=0 accepts a byte: host_data is captured and host_ack goes to 1 on the next clk edge.
  - host_ack stays 1 until stb_s is seen low, then returns to 0 on the next edge.
  - Exactly one byte is accepted per stb high phase.
  - Latency from host_stb rising to host_ack rising is SYNC_STAGES+1 clk cycles.
- Byte FSM, advanced once per accepted byte:
  - IDLE: cpu_hold=0. When load_en=1, go to SYNC. cpu_hold=1, done=0, err=0.
  - SYNC: byte==SYNC_BYTE goes to LEN_LO; any other byte goes to ERROR.
  - LEN_LO: store the low byte, go to LEN_HI.
  - LEN_HI: store the high byte, clear the payload index and the checksum accumulator. Go to DATA if LEN!=0, else go to CSUM.
  - DATA: on each byte, in the same cycle host_ack rises:
    - mem_we=1 for exactly one cycle,
    - mem_addr=index, mem_wdata=byte,
    - accumulator += byte (mod 256), index += 1.
    - After the LEN-th byte, go to CSUM.
  - CSUM: if (accumulator + byte) mod 256 == 0, go to DONE; else go to ERROR.
  - DONE: done=1, cpu_hold=0. Stay until load_en=0, then go to IDLE with done cleared.
  - ERROR: err=1, cpu_hold=1. Stay until load_en=0, then go to IDLE with err cleared.
- Boundary conditions:
  - load_en=0 in any state other than IDLE aborts to IDLE on the next edge: cpu_hold=0, no further mem_we, and host_ack follows its normal release rule.
  - RAM bytes already written are kept.
  - LEN=2^ADDR_W-1 is the maximum; index never wraps within a frame.
  - Bytes arriving in DONE or ERROR are acknowledged and discarded.
  - mem_addr holds its last value between writes.
  - rst_n asserted mid-frame returns everything to reset values immediately.
  - load_en rising on the same edge as a stb_s rise while in IDLE: the FSM enters SYNC, and that byte is acknowledged and discarded. The host must not strobe until cpu_hold=1.

Decomposition:
- Shared package jrb8_pkg:
  - loader state enum (IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR),
  - SYNC_BYTE default,
  - ADDR_W default.
- One sub-module, jrb8_hs_sync: the stb synchroniser plus the ack handshake. It outputs a one-cycle byte_valid pulse and the captured byte.
- The top-level loader contains the frame FSM, counters and the checksum.

Test Plan:
- Frame A5 03 00 11 22 33 9A with load_en=1:
  - writes (0,11), (1,22), (2,33), one mem_we pulse each;
  - then done=1, cpu_hold=0, err=0.
- Same frame with CSUM=9B -> three writes occur, then err=1, cpu_hold=1, done=0.
- First byte 5A -> ERROR immediately, zero mem_we pulses. Then drop load_en -> err=0, cpu_hold=0.
- Frame A5 00 00 00 -> no writes, done=1.
- Hold host_stb high for 20 cycles on one byte -> exactly one mem_we.
- Measure host_ack rise at SYNC_STAGES+1 = 3 cycles after the host_stb rise.
- Drop load_en after the second payload byte of a 3-byte frame:
  - exactly two writes, FSM=IDLE, cpu_hold=0;
  - a new full frame then loads correctly.
